// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared constants, types and helpers for the msrv32 data-memory responder
package msrv32_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } dmem_state_e;

    // NONSEQ and SEQ carry a transfer; IDLE and BUSY do not.
    function automatic logic is_transfer(input logic [1:0] htrans);
        logic r;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/msrv32_dmem_array.sv
// rtl/msrv32_dmem_array.sv - word array with byte-lane write enables and asynchronous read
module msrv32_dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             i_clk,
    input  logic [IDX_W-1:0] i_index,
    input  logic [31:0]      i_wdata,
    input  logic [3:0]       i_we,
    output logic [31:0]      o_rdata
);

    // Contents are intentionally never reset.
    logic [31:0] r_mem [DEPTH_WORDS];

    // Each enabled byte lane takes its own lane of the write data.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_index][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/msrv32_dmem_responder.sv
// rtl/msrv32_dmem_responder.sv - data-memory responder FSM with wait states; MSRV32_DMEM_ERR_EN enables out-of-range ERROR responses
module msrv32_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] ms_riscv32_mp_dmaddr_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
    input  logic        ms_riscv32_mp_dmwr_req_in,
    input  logic [1:0]  ahb_htrans_in,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic        ahb_ready_out,
    output logic        ahb_resp_out
);
    import msrv32_pkg::*;

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_e      r_state;
    dmem_state_e      w_next_state;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_index;
    logic [31:0]      r_wdata;
    logic [3:0]       r_mask;
    logic             r_wr;

    logic             w_ready;
    logic             w_resp;
    logic             w_accept;
    logic             w_out_of_range;
    logic [31:0]      w_rdata;
    logic [31:0]      w_dout;
    logic [3:0]       w_we;
    logic             w_unused;

    // Byte offset and (when not range-checked) upper bits carry no information here.
    assign w_unused = &{1'b0, ms_riscv32_mp_dmaddr_in};

`ifdef MSRV32_DMEM_ERR_EN
    assign w_out_of_range = |(ms_riscv32_mp_dmaddr_in >> (IDX_W + 2));
`else
    assign w_out_of_range = 1'b0;
`endif

    assign w_accept = is_transfer(ahb_htrans_in) && w_ready;

    // State register.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: ready states may accept a new request; WAIT runs the counter down; errors take two cycles.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (w_accept) begin
                    if (w_out_of_range) begin
                        w_next_state = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_ERR1: w_next_state = ST_ERR2;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs: read data only in a read completion, ready low in WAIT/ERR1, resp high only in error states.
    always_comb begin
        w_ready = 1'b1;
        w_resp  = RESP_OKAY;
        w_dout  = 32'd0;
        case (r_state)
            ST_WAIT: w_ready = 1'b0;
            ST_DONE: begin
                if (!r_wr) begin
                    w_dout = w_rdata;
                end
            end
            ST_ERR1: begin
                w_ready = 1'b0;
`ifdef MSRV32_DMEM_ERR_EN
                w_resp  = RESP_ERROR;
`endif
            end
            ST_ERR2: begin
`ifdef MSRV32_DMEM_ERR_EN
                w_resp  = RESP_ERROR;
`endif
            end
            default: begin
                w_ready = 1'b1;
            end
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_cnt   <= 4'd0;
            r_index <= '0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
            r_wr    <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= CNT_LOAD;
            r_index <= ms_riscv32_mp_dmaddr_in[IDX_W+1:2];
            r_wdata <= ms_riscv32_mp_dmdata_in;
            r_mask  <= ms_riscv32_mp_dmwr_mask_in;
            r_wr    <= ms_riscv32_mp_dmwr_req_in;
        end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // The write commits at the closing edge of DONE, so reset during WAIT drops it.
    assign w_we = (r_state == ST_DONE && r_wr) ? r_mask : 4'd0;

    msrv32_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .i_clk   (ms_riscv32_mp_clk_in),
        .i_index (r_index),
        .i_wdata (r_wdata),
        .i_we    (w_we),
        .o_rdata (w_rdata)
    );

    assign ms_riscv32_mp_dmdata_out = w_dout;
    assign ahb_ready_out            = w_ready;
    assign ahb_resp_out             = w_resp;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// tb/tb_msrv32_dmem_responder.sv - directed table-driven bench for msrv32_dmem_responder
module tb_msrv32_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_mask;
    logic        a_wr, a_ready, a_resp;
    logic [1:0]  a_htrans;

    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_mask;
    logic        b_wr, b_ready, b_resp;
    logic [1:0]  b_htrans;

    msrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut_a (
        .ms_riscv32_mp_clk_in       (clk),
        .ms_riscv32_mp_rst_in       (rst),
        .ms_riscv32_mp_dmaddr_in    (a_addr),
        .ms_riscv32_mp_dmdata_in    (a_wdata),
        .ms_riscv32_mp_dmwr_mask_in (a_mask),
        .ms_riscv32_mp_dmwr_req_in  (a_wr),
        .ahb_htrans_in              (a_htrans),
        .ms_riscv32_mp_dmdata_out   (a_rdata),
        .ahb_ready_out              (a_ready),
        .ahb_resp_out               (a_resp)
    );

    msrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
        .ms_riscv32_mp_clk_in       (clk),
        .ms_riscv32_mp_rst_in       (rst),
        .ms_riscv32_mp_dmaddr_in    (b_addr),
        .ms_riscv32_mp_dmdata_in    (b_wdata),
        .ms_riscv32_mp_dmwr_mask_in (b_mask),
        .ms_riscv32_mp_dmwr_req_in  (b_wr),
        .ahb_htrans_in              (b_htrans),
        .ms_riscv32_mp_dmdata_out   (b_rdata),
        .ahb_ready_out              (b_ready),
        .ahb_resp_out               (b_resp)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Called at posedge+1 with dut_a idle; one full WAIT_STATES=1 transfer.
    task automatic a_xfer(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask, input logic [31:0] exp_rd);
        int n;
        a_htrans = 2'b10; a_wr = wr; a_addr = addr; a_wdata = data; a_mask = mask;
        @(posedge clk); #1;
        a_htrans = 2'b00;
        n = 0;
        while (!a_ready && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk({name, " wait_cycles"}, n, 32'd1);
        chk({name, " done_ready"}, {31'd0, a_ready}, 32'd1);
        chk({name, " done_resp"}, {31'd0, a_resp}, 32'd0);
        chk({name, " done_rdata"}, a_rdata, exp_rd);
        @(posedge clk); #1;
        chk({name, " idle_rdata"}, a_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0011, 32'h0000_AA00, 4'b0010, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'hDEAD_AAEF};
        vecs[4]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF,    32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0,    32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0,    32'h1122_3344};
        vecs[7]  = '{1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b1001, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0,    32'hAA22_33DD};
        vecs[9]  = '{1'b1, 32'h0000_0030, 32'h0,         4'hF,    32'h0};
        vecs[10] = '{1'b1, 32'h0000_0000, 32'h0,         4'hF,    32'h0};
        vecs[11] = '{1'b1, 32'h0000_0050, 32'hCAFE_F00D, 4'hF,    32'h0};
        vecs[12] = '{1'b0, 32'h0000_0043, 32'h0,         4'h0,    32'hAA22_33DD};

        a_htrans = 2'b00; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_mask = '0;
        b_htrans = 2'b00; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_mask = '0;

        // Reset state
        #12;
        chk("rst a_ready", {31'd0, a_ready}, 32'd1);
        chk("rst a_resp",  {31'd0, a_resp},  32'd0);
        chk("rst a_rdata", a_rdata, 32'd0);
        chk("rst b_ready", {31'd0, b_ready}, 32'd1);
        chk("rst b_rdata", b_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of single transfers on the one-wait-state responder
        for (int i = 0; i < 13; i++) begin
            a_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                   vecs[i].mask, vecs[i].exp_rd);
        end

        // BUSY htrans is not a request
        a_htrans = 2'b01; a_wr = 1'b1; a_addr = 32'h50; a_wdata = 32'h0; a_mask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("busy%0d ready", i), {31'd0, a_ready}, 32'd1);
            chk($sformatf("busy%0d rdata", i), a_rdata, 32'd0);
        end
        a_htrans = 2'b00;
        a_xfer("busy readback", 1'b0, 32'h50, 32'h0, 4'h0, 32'hCAFE_F00D);

        // Reset during WAIT of a write drops the write
        a_htrans = 2'b10; a_wr = 1'b1; a_addr = 32'h30; a_wdata = 32'hFFFF_FFFF; a_mask = 4'hF;
        @(posedge clk); #1;
        a_htrans = 2'b00;
        chk("midrst in_wait ready", {31'd0, a_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst async ready", {31'd0, a_ready}, 32'd1);
        chk("midrst async resp",  {31'd0, a_resp},  32'd0);
        chk("midrst async rdata", a_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        a_xfer("midrst readback", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0);

        // Zero wait states: pipelined write then read of the same word
        b_htrans = 2'b10; b_wr = 1'b1; b_addr = 32'h20; b_wdata = 32'h1234_5678; b_mask = 4'hF;
        @(posedge clk); #1;
        chk("pipe wr ready", {31'd0, b_ready}, 32'd1);
        chk("pipe wr rdata", b_rdata, 32'd0);
        b_wr = 1'b0; b_wdata = 32'h0; b_mask = 4'h0;
        @(posedge clk); #1;
        b_htrans = 2'b00;
        chk("pipe rd ready", {31'd0, b_ready}, 32'd1);
        chk("pipe rd resp",  {31'd0, b_resp},  32'd0);
        chk("pipe rd rdata", b_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        chk("pipe idle ready", {31'd0, b_ready}, 32'd1);
        chk("pipe idle rdata", b_rdata, 32'd0);

        // Address above the index field
`ifdef MSRV32_DMEM_ERR_EN
        a_htrans = 2'b10; a_wr = 1'b1; a_addr = 32'h0001_0000; a_wdata = 32'h1; a_mask = 4'hF;
        @(posedge clk); #1;
        a_htrans = 2'b00;
        chk("oor err1 ready", {31'd0, a_ready}, 32'd0);
        chk("oor err1 resp",  {31'd0, a_resp},  32'd1);
        @(posedge clk); #1;
        chk("oor err2 ready", {31'd0, a_ready}, 32'd1);
        chk("oor err2 resp",  {31'd0, a_resp},  32'd1);
        chk("oor err2 rdata", a_rdata, 32'd0);
        @(posedge clk); #1;
        chk("oor idle resp",  {31'd0, a_resp},  32'd0);
        a_xfer("oor readback", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
`else
        a_xfer("oor write", 1'b1, 32'h0001_0000, 32'h1, 4'hF, 32'h0);
        a_xfer("oor readback", 1'b0, 32'h0, 32'h0, 4'h0, 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
